// File: rtl/seq_tx_pkg.sv
// ============================================================================
// Module  : seq_tx_pkg
// Purpose : Shared types and constants for the serial pattern transmitter
//           and the detector-side benches that consume its stream.
// Contents: tx_state_e  - transmitter state encoding (2 bits)
//           LINE_IDLE   - level driven on the serial line when not sending
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b0;

endpackage : seq_tx_pkg

`default_nettype wire

// File: rtl/seq_pattern_tx_bit_tick_gen.sv
// ============================================================================
// Module  : bit_tick_gen
// Purpose : Bit-period prescaler. Counts 0..DIV-1 while enabled and flags the
//           last cycle of each bit period so the owner can advance a bit.
// Ports   : clk_i      - clock, posedge
//           rst_ni     - synchronous active-low reset
//           clr_i      - synchronous clear (frame start / idle)
//           en_i       - count enable (a bit is on the line)
//           bit_end_o  - high during the final cycle of a bit period
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_tick_gen
    import seq_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    // DIV=1 still needs a legal (1-bit) counter that simply stays at zero.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = en_i && (cnt_q == c_LAST);

endmodule : bit_tick_gen

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module  : seq_pattern_tx
// Purpose : Serial pattern transmitter. Captures a parallel pattern of
//           programmable length and shifts it out MSB-first, holding each
//           bit for DIV clocks, with a Start/Busy/Done handshake.
// Ports   : clk_i    - clock, posedge
//           rst_ni   - synchronous active-low reset
//           start_i  - send request, sampled only in IDLE
//           data_i   - pattern; bit len-1 is sent first
//           len_i    - number of bits to send (clamped to WIDTH, 0 ignored)
//           out1_o   - serial line, idles low
//           busy_o   - frame in progress
//           done_o   - one-cycle end-of-frame pulse
// Config  : `define PARITY_EN adds an even-parity bit after the data bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(WIDTH+1)-1:0] len_i,
    output logic                       out1_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] c_MAX_LEN = LW'(WIDTH);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LW-1:0]    bits_q,  bits_d;
    logic             out1_q,  out1_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef PARITY_EN
    logic             par_q,   par_d;
`endif

    logic [LW-1:0]    w_eff_len;
    logic [WIDTH-1:0] w_aligned;
    logic             w_bit_end;

    // Left-align the pattern so the first bit to send always sits at the MSB;
    // the unused low bits are zero, which also makes ^w_aligned the parity.
    assign w_eff_len = (len_i > c_MAX_LEN) ? c_MAX_LEN : len_i;
    assign w_aligned = data_i << (c_MAX_LEN - w_eff_len);

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (state_q == IDLE),
        .en_i      ((state_q == SHIFT) || (state_q == PARITY)),
        .bit_end_o (w_bit_end)
    );

    // Outputs are computed one cycle ahead and registered, so the line
    // reflects the state that is entered at the same edge.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bits_d  = bits_q;
        out1_d  = LINE_IDLE;
        busy_d  = 1'b1;
        done_d  = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_i && (len_i != '0)) begin
                    state_d = SHIFT;
                    shreg_d = w_aligned;
                    bits_d  = w_eff_len;
                    out1_d  = w_aligned[WIDTH-1];
                    busy_d  = 1'b1;
`ifdef PARITY_EN
                    par_d   = ^w_aligned;
`endif
                end
            end
            SHIFT: begin
                out1_d = out1_q;
                if (w_bit_end) begin
                    if (bits_q == LW'(1)) begin
`ifdef PARITY_EN
                        state_d = PARITY;
                        out1_d  = par_q;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        out1_d  = LINE_IDLE;
`endif
                    end else begin
                        shreg_d = shreg_q << 1;
                        bits_d  = bits_q - 1'b1;
                        out1_d  = shreg_q[WIDTH-2];
                    end
                end
            end
            PARITY: begin
                out1_d = out1_q;
                if (w_bit_end) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    out1_d  = LINE_IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bits_q  <= '0;
            out1_q  <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            out1_q  <= out1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out1_o = out1_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule : seq_pattern_tx

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
// Module  : tb_seq_pattern_tx
// Purpose : Self-checking bench for seq_pattern_tx (WIDTH=8, DIV=4).
//           Table of directed frames plus hand-written reset / ignore cases.
// Config  : honours `define PARITY_EN for expected frame contents.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] len = '0;
    logic       out1, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .data_i  (data),
        .len_i   (len),
        .out1_o  (out1),
        .busy_o  (busy),
        .done_o  (done)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         nbits;   // effective length after clamping
        logic [7:0] bits;    // expected bits, bits[nbits-1] sent first
        logic       par;     // even parity of the sent bits
        bit         hold;    // keep start high for the whole frame
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sends one frame and checks every cycle of the line plus the handshake.
    task automatic send_check(input vec_t v, input int idx);
        int busy_cnt, done_cnt, done_pos, bit_err, bi;
        logic exp_bit;
        busy_cnt = 0; done_cnt = 0; done_pos = -1; bit_err = 0;
        @(negedge clk);
        data = v.data; len = v.len; start = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (!v.hold) start = 1'b0;
            data = ~v.data;          // must not disturb the captured frame
            len  = 4'd1;
            if (!busy) break;
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_pos = busy_cnt;
            end
            bi = (busy_cnt - 1) / DIV;
            if (bi < v.nbits)              exp_bit = v.bits[v.nbits-1-bi];
            else if (PAR == 1 && bi == v.nbits) exp_bit = v.par;
            else                           exp_bit = 1'b0;
            if (out1 !== exp_bit) bit_err++;
        end
        start = 1'b0;
        check($sformatf("v%0d busy_len", idx), busy_cnt, v.nbits * DIV + 1 + PAR * DIV);
        check($sformatf("v%0d line_bits_err", idx), bit_err, 0);
        check($sformatf("v%0d done_count", idx), done_cnt, 1);
        check($sformatf("v%0d done_pos", idx), done_pos, busy_cnt);
        // at least one idle cycle before anything else can start
        @(negedge clk);
        check($sformatf("v%0d idle_after", idx), int'(busy), 0);
    endtask

    int  done_seen;
    int  busy_seen;

    initial begin
        vecs[0] = '{8'h05, 4'd3,  3, 8'b0000_0101, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 4'd15, 8, 8'hA5,        1'b0, 1'b0};
        vecs[2] = '{8'h02, 4'd2,  2, 8'b0000_0010, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 4'd1,  1, 8'b0000_0001, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 4'd1,  1, 8'b0000_0000, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 4'd8,  8, 8'h80,        1'b1, 1'b0};
        vecs[6] = '{8'h3C, 4'd8,  8, 8'h3C,        1'b0, 1'b1};
        vecs[7] = '{8'hF6, 4'd4,  4, 8'b0000_0110, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out1", int'(out1), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        rst_n = 1'b1;

        // Len==0 start is ignored
        @(negedge clk);
        data = 8'hFF; len = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        check("len0 busy", busy_seen, 0);
        check("len0 done", done_seen, 0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) send_check(vecs[i], i);

        // Reset mid-frame aborts without a Done pulse
        @(negedge clk);
        data = 8'hA5; len = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midframe busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe rst out1", int'(out1), 0);
        check("midframe rst busy", int'(busy), 0);
        check("midframe rst done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        check("midframe no done", done_seen, 0);
        check("midframe stays idle", busy_seen, 0);

        // Recovery after abort
        send_check(vecs[0], 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_pattern_tx

`default_nettype wire
